uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer placed directly downstream of uart_rx: captures each decoded byte
//  on its single-cycle valid strobe (no backpressure) and holds it for the register/host side.

---
 rtl/uart_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Receive-side byte FIFO downstream of uart_rx. Captures each
//             decoded byte on its valid strobe and presents it through a
//             first-word-fall-through valid/ready read port. It also reports
//             the fill level, a threshold flag and a sticky overrun flag.
//             The optional idle-timeout flag is enabled by defining
//             UART_RX_FIFO_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int WIDTH         = 8,
    parameter int THRESHOLD     = 8,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    input  logic                       rd_ready_i,
    input  logic                       flush_i,
    input  logic                       overrun_clr_i,
    input  logic                       tick_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       level_o,
    output logic                       overrun_o,
    output logic                       timeout_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    localparam logic [c_AW-1:0] c_PTR_ONE   = {{(c_AW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_CNT_ONE   = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_CNT_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_THR   = c_CW'(THRESHOLD);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_overrun;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    // Flags decode straight from the registered count, so a write strobe
    // never reaches rd_valid_o combinationally.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_DEPTH);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept
    // a byte when the consumer reads. Flush suppresses both operations.
    assign w_pop  = !w_empty && rd_ready_i && !flush_i;
    assign w_push = wr_valid_i && (!w_full || w_pop) && !flush_i;

    // Next fill level from the push/pop combination
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; cleared on reset so the head reads zero before any write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy separately
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky overrun: a dropped byte outranks a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_overrun <= 1'b0;
        end else if (flush_i) begin
            r_overrun <= 1'b0;
        end else if (wr_valid_i && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_TW-1:0] c_TO_MAX  = c_TW'(TIMEOUT_TICKS);
    localparam logic [c_TW-1:0] c_TO_ONE  = {{(c_TW-1){1'b0}}, 1'b1};

    logic [c_TW-1:0] r_idle_cnt;

    // Idle bit-time counter: restarts on any FIFO activity or while empty,
    // saturates once the timeout point is reached
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idle_cnt <= '0;
        end else if (flush_i || w_push || w_pop || w_empty) begin
            r_idle_cnt <= '0;
        end else if (tick_i && (r_idle_cnt != c_TO_MAX)) begin
            r_idle_cnt <= r_idle_cnt + c_TO_ONE;
        end
    end

    assign timeout_o = (r_idle_cnt == c_TO_MAX) && !w_empty;
`else
    logic w_unused_tick;

    assign w_unused_tick = tick_i;
    assign timeout_o     = 1'b0;
`endif

    assign rd_data_o  = r_mem[r_rd_ptr];
    assign rd_valid_o = !w_empty;
    assign count_o    = r_count;
    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign level_o    = (r_count >= c_CNT_THR);
    assign overrun_o  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo (default
//             parameters). Covers the timeout flag when
//             UART_RX_FIFO_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk_i;
    logic       rst_i;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       rd_ready_i;
    logic       flush_i;
    logic       overrun_clr_i;
    logic       tick_i;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       level_o;
    logic       overrun_o;
    logic       timeout_o;

    int vectors;
    int miscompares;
    logic [7:0] q [$];

    uart_rx_fifo #(
        .DEPTH         (16),
        .WIDTH         (8),
        .THRESHOLD     (8),
        .TIMEOUT_TICKS (40)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_valid_i    (wr_valid_i),
        .wr_data_i     (wr_data_i),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .rd_ready_i    (rd_ready_i),
        .flush_i       (flush_i),
        .overrun_clr_i (overrun_clr_i),
        .tick_i        (tick_i),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .level_o       (level_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        cyc();
        wr_valid_i = 1'b0;
    endtask

    task automatic pop();
        rd_ready_i = 1'b1;
        cyc();
        rd_ready_i = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_i         = 1'b0;
        wr_valid_i    = 1'b0;
        wr_data_i     = 8'h00;
        rd_ready_i    = 1'b0;
        flush_i       = 1'b0;
        overrun_clr_i = 1'b0;
        tick_i        = 1'b0;
        cyc();
        cyc();

        // Reset state
        chk("rst_count",   32'(count_o),    32'd0);
        chk("rst_empty",   32'(empty_o),    32'd1);
        chk("rst_valid",   32'(rd_valid_o), 32'd0);
        chk("rst_full",    32'(full_o),     32'd0);
        chk("rst_level",   32'(level_o),    32'd0);
        chk("rst_overrun", 32'(overrun_o),  32'd0);
        chk("rst_timeout", 32'(timeout_o),  32'd0);
        chk("rst_data",    32'(rd_data_o),  32'd0);
        rst_i = 1'b1;
        cyc();

        // 1: asynchronous reset mid-stream
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("t1_count3", 32'(count_o), 32'd3);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t1_async_count", 32'(count_o),    32'd0);
        chk("t1_async_empty", 32'(empty_o),    32'd1);
        chk("t1_async_valid", 32'(rd_valid_o), 32'd0);
        cyc();
        rst_i = 1'b1;
        cyc();

        // 2: single byte latency and pop
        push(8'hA5);
        chk("t2_valid", 32'(rd_valid_o), 32'd1);
        chk("t2_data",  32'(rd_data_o),  32'hA5);
        chk("t2_count", 32'(count_o),    32'd1);
        cyc();
        chk("t2_hold",  32'(rd_data_o),  32'hA5);
        pop();
        chk("t2_empty", 32'(empty_o),    32'd1);
        pop();
        chk("t2_underflow_count", 32'(count_o), 32'd0);

        // 3: fill, overrun, ordered drain
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        chk("t3_full",      32'(full_o),    32'd1);
        chk("t3_ovr_pre",   32'(overrun_o), 32'd0);
        push(8'hFF);
        chk("t3_overrun",   32'(overrun_o), 32'd1);
        chk("t3_count16",   32'(count_o),   32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", 32'(rd_data_o), 32'(i));
            pop();
        end
        chk("t3_empty",     32'(empty_o),   32'd1);
        chk("t3_ovr_stick", 32'(overrun_o), 32'd1);
        overrun_clr_i = 1'b1;
        cyc();
        overrun_clr_i = 1'b0;
        chk("t3_ovr_clr",   32'(overrun_o), 32'd0);

        // 4: full with simultaneous push/pop, then wrap exercise
        q.delete();
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h20 + i));
            q.push_back(8'(8'h20 + i));
        end
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h55;
        rd_ready_i = 1'b1;
        chk("t4_head", 32'(rd_data_o), 32'h20);
        cyc();
        void'(q.pop_front());
        q.push_back(8'h55);
        chk("t4_count16", 32'(count_o),   32'd16);
        chk("t4_no_ovr",  32'(overrun_o), 32'd0);
        chk("t4_head2",   32'(rd_data_o), 32'h21);
        for (int k = 0; k < 40; k++) begin
            wr_data_i = 8'(8'h60 + k);
            chk("t4_pair", 32'(rd_data_o), 32'(q[0]));
            cyc();
            void'(q.pop_front());
            q.push_back(8'(8'h60 + k));
        end
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        chk("t4_count_after", 32'(count_o),   32'd16);
        chk("t4_ovr_after",   32'(overrun_o), 32'd0);
        while (q.size() > 0) begin
            chk("t4_drain", 32'(rd_data_o), 32'(q[0]));
            void'(q.pop_front());
            pop();
        end
        chk("t4_empty", 32'(empty_o), 32'd1);

        // 5: threshold flag and flush
        for (int i = 0; i < 7; i++) begin
            push(8'(8'h40 + i));
        end
        chk("t5_level7", 32'(level_o), 32'd0);
        push(8'h47);
        chk("t5_level8", 32'(level_o), 32'd1);
        flush_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h99;
        cyc();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        chk("t5_fl_count", 32'(count_o),   32'd0);
        chk("t5_fl_level", 32'(level_o),   32'd0);
        chk("t5_fl_ovr",   32'(overrun_o), 32'd0);
        cyc();
        chk("t5_discard",  32'(rd_valid_o), 32'd0);
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
        end
        chk("t5_ovr_set",  32'(overrun_o), 32'd1);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("t5_fl_ovr2",  32'(overrun_o), 32'd0);
        chk("t5_fl_empty", 32'(empty_o),   32'd1);

        // 6: idle timeout
        push(8'h77);
        tick_i = 1'b1;
        for (int i = 0; i < 39; i++) begin
            cyc();
        end
        chk("t6_to_39", 32'(timeout_o), 32'd0);
        cyc();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("t6_to_40", 32'(timeout_o), 32'd1);
        cyc();
        chk("t6_to_sat", 32'(timeout_o), 32'd1);
`else
        chk("t6_to_off", 32'(timeout_o), 32'd0);
`endif
        tick_i = 1'b0;
        pop();
        chk("t6_to_pop", 32'(timeout_o), 32'd0);
        chk("t6_empty",  32'(empty_o),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
